move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the move FIFO depth in entries (power of two).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 5000000, giving the idle gap between consecutive moves in clock cycles.
REQ-003 The block SHALL have parameter START_TIMEOUT, default 1000, giving the maximum cycles to wait for move_done to fall after move_start.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 move_in  input  4  move code to enqueue (R=2, Ri=3, U=4, Ui=5, F=6, Fi=7, L=8, Li=9, B=10, Bi=11, D=12, Di=13).
REQ-007 move_valid  input  1  enqueue request for move_in.
REQ-008 move_ready  output  1  FIFO not full; high means a write this cycle is accepted.
REQ-009 go  input  1  start executing queued moves.
REQ-010 abort  input  1  stop after the current move and flush the FIFO.
REQ-011 move_done  input  1  high when all stepper drivers are idle.
REQ-012 next_move  output  4  move code presented to the stepper front end.
REQ-013 move_start  output  1  one-cycle pulse launching next_move.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 seq_done  output  1  one-cycle pulse when a run ends.
REQ-016 move_count  output  8  moves completed in the current run; saturates at 255.
REQ-017 fill  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 err  output  2  sticky flags: bit0 illegal code written, bit1 start timeout.

Function
REQ-019 A write SHALL occur when move_valid and move_ready are both high and move_in is in 2..13; codes 0, 1, 14, 15 SHALL be discarded and set err[0].
REQ-020 A write with the FIFO full SHALL be dropped without any change to FIFO contents or err.
REQ-021 Simultaneous write and pop SHALL leave fill unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, SETTLE, FINISH.
REQ-023 IDLE: on go=1 with fill>0, clear move_count and go to ISSUE; go with an empty FIFO SHALL be ignored.
REQ-024 ISSUE: pop the head into the next_move register and go to WAIT_LOW; move_start SHALL pulse in the cycle after the pop, with next_move already valid.
REQ-025 next_move SHALL stay constant from the move_start cycle until SETTLE exits, because direction is decoded combinationally from it downstream.
REQ-026 WAIT_LOW: go to WAIT_HIGH on the first cycle move_done=0.
REQ-027 WAIT_LOW: after START_TIMEOUT cycles without move_done=0, set err[1] and go to SETTLE.
REQ-028 WAIT_HIGH: on move_done=1, increment move_count and go to SETTLE; there SHALL be no timeout in this state.
REQ-029 SETTLE: count SETTLE_CYCLES cycles.
REQ-030 At the end of SETTLE: go to FINISH if the abort latch is set or the FIFO is empty, otherwise go to ISSUE.
REQ-031 Writes SHALL be accepted in all states, so moves enqueued during a run execute in the same run.
REQ-032 abort pulsed in any non-IDLE state SHALL set an abort latch; the in-flight move SHALL complete, and the latch SHALL force FINISH after SETTLE.
REQ-033 abort in IDLE SHALL flush the FIFO immediately.
REQ-034 FINISH: flush the FIFO if the abort latch is set, clear the latch, set next_move=15 (NULL), pulse seq_done for one cycle, return to IDLE.
REQ-035 go received while busy SHALL be ignored.
REQ-036 err SHALL clear only on reset.

Reset
REQ-037 reset_n=0 at a rising edge SHALL force IDLE, empty the FIFO, and set next_move=15, move_start=0, busy=0, seq_done=0, move_count=0, fill=0, err=0, and the abort latch to 0.
REQ-038 Reset mid-move SHALL take effect on that same edge with no completion of the move and no seq_done pulse.

Verification
REQ-039 Write 2, 5, 13, then pulse go; model move_done low 3 cycles after each start -> exactly three move_start pulses carrying 2, 5, 13, each ≥SETTLE_CYCLES apart; move_count=3; one seq_done; next_move=15 afterwards.
REQ-040 Write 0, 14, 15, then 6 -> fill=1, err=2'b01, and only code 6 is executed after go.
REQ-041 Write DEPTH+1 valid codes back-to-back -> move_ready falls at fill=DEPTH; the extra write is dropped; the FIFO drains in write order, including across pointer wrap.
REQ-042 Hold move_done=1 permanently, then go with one move -> err[1] set after START_TIMEOUT cycles, move_count=0, seq_done pulses.
REQ-043 Queue 4 moves, go, pulse abort during the first WAIT_HIGH -> the first move completes, no further move_start, fill=0 at seq_done, move_count=1.
REQ-044 Assert reset_n=0 during WAIT_HIGH -> on the next edge all outputs hold their REQ-037 values and no seq_done is emitted.

Source files
------------

// File: rtl/move_sequencer_if.sv
// Move sequencer bus: enqueue handshake, run control, stepper handshake and
// status. The slave modport is the sequencer side, master is the controller
// and stepper-model side.
//   move_in/move_valid/move_ready : move FIFO write port
//   go/abort                      : run control
//   move_done                     : stepper drivers idle
//   next_move/move_start          : move launched to the stepper front end
//   busy/seq_done/move_count      : run status
//   fill/err                      : FIFO occupancy and sticky error flags
interface move_sequencer_if #(
    parameter int DEPTH = 32
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [3:0]    move_in;
    logic          move_valid;
    logic          move_ready;
    logic          go;
    logic          abort;
    logic          move_done;
    logic [3:0]    next_move;
    logic          move_start;
    logic          busy;
    logic          seq_done;
    logic [7:0]    move_count;
    logic [FW-1:0] fill;
    logic [1:0]    err;

    modport slave (
        input  move_in, move_valid, go, abort, move_done,
        output move_ready, next_move, move_start, busy, seq_done,
               move_count, fill, err
    );

    modport master (
        output move_in, move_valid, go, abort, move_done,
        input  move_ready, next_move, move_start, busy, seq_done,
               move_count, fill, err
    );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: queues cube-face move codes in a FIFO and issues them one at
// a time to the stepper front end, waiting for the drivers to go busy and then
// idle again, followed by a settle gap before the next move.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : move_sequencer_if.slave (FIFO write, go/abort, stepper handshake,
//             status outputs)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for go with a non-empty FIFO; abort flushes the FIFO
// ISSUE      | pop head into next_move
// WAIT_LOW   | move_start issued, waiting for move_done to fall (timeout)
// WAIT_HIGH  | stepper running, waiting for move_done to rise
// SETTLE     | idle gap between moves
// FINISH     | end of run: optional flush, next_move=NULL, seq_done pulse
module move_sequencer #(
    parameter int DEPTH         = 32,
    parameter int SETTLE_CYCLES = 5000000,
    parameter int START_TIMEOUT = 1000
) (
    input logic             clock,
    input logic             reset_n,
    move_sequencer_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = AW + 1;
    localparam int TMAX = (SETTLE_CYCLES > START_TIMEOUT) ? SETTLE_CYCLES : START_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [3:0] NULL_MOVE = 4'd15;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    logic [2:0]    state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill;
    logic [TW-1:0] timer;
    logic          abort_lat;
    logic [3:0]    next_move;
    logic          move_start;
    logic          seq_done;
    logic [7:0]    move_count;
    logic [1:0]    err;

    logic code_legal;
    logic wr_try;
    logic wr_en;
    logic pop;
    logic flush;

    always_comb begin
        code_legal = (bus.move_in >= 4'd2) && (bus.move_in <= 4'd13);
        // wr_try: handshake completes; the code itself may still be rejected
        wr_try     = bus.move_valid && (fill != FW'(DEPTH));
        flush      = ((state == S_IDLE) && bus.abort) ||
                     ((state == S_FINISH) && abort_lat);
        wr_en      = wr_try && code_legal && !flush;
        pop        = (state == S_ISSUE);
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= bus.move_in;
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + FW'(wr_en) - FW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            abort_lat  <= 1'b0;
            next_move  <= NULL_MOVE;
            move_start <= 1'b0;
            seq_done   <= 1'b0;
            move_count <= '0;
            err        <= '0;
        end else begin
            move_start <= 1'b0;
            seq_done   <= 1'b0;
            if (wr_try && !code_legal)
                err[0] <= 1'b1;
            if (bus.abort && (state != S_IDLE))
                abort_lat <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.go && (fill != '0)) begin
                        move_count <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    next_move  <= mem[rd_ptr];
                    move_start <= 1'b1;
                    timer      <= TW'(START_TIMEOUT - 1);
                    state      <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!bus.move_done) begin
                        state <= S_WAIT_HIGH;
                    end else if (timer == '0) begin
                        err[1] <= 1'b1;
                        timer  <= TW'(SETTLE_CYCLES - 1);
                        state  <= S_SETTLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (bus.move_done) begin
                        if (move_count != 8'hFF)
                            move_count <= move_count + 8'd1;
                        timer <= TW'(SETTLE_CYCLES - 1);
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        if (abort_lat || (fill == '0))
                            state <= S_FINISH;
                        else
                            state <= S_ISSUE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_FINISH: begin
                    // clearing here overrides an abort arriving in this cycle
                    abort_lat <= 1'b0;
                    next_move <= NULL_MOVE;
                    seq_done  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.move_ready = (fill != FW'(DEPTH));
    assign bus.next_move  = next_move;
    assign bus.move_start = move_start;
    assign bus.busy       = (state != S_IDLE);
    assign bus.seq_done   = seq_done;
    assign bus.move_count = move_count;
    assign bus.fill       = fill;
    assign bus.err        = err;
endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: table of FIFO write vectors, hand-written run
// sequences (drain order, wrap, timeout, abort, reset mid-move) and randomized
// runs checked against a queue-based model of the expected move stream.
module tb_move_sequencer;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 8;
    localparam int TOUT   = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    move_sequencer_if #(.DEPTH(DEPTH)) bus();

    move_sequencer #(
        .DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE),
        .START_TIMEOUT(TOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit resp_on = 1'b1;

    logic [3:0] starts[$];
    int         start_cyc[$];
    logic [3:0] exp_q[$];

    typedef struct {
        bit         rst;
        bit         valid;
        logic [3:0] code;
        int         exp_fill;
        int         exp_err;
        int         exp_ready;
    } vec_t;

    vec_t vecs [11];

    always @(posedge clock) cyc <= cyc + 1;

    // log every launched move
    initial begin
        forever begin
            @(negedge clock);
            if (bus.move_start) begin
                starts.push_back(bus.next_move);
                start_cyc.push_back(cyc);
            end
        end
    end

    // stepper model: drivers go busy 2 cycles after a start, for 2 cycles
    initial begin
        bus.move_done = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.move_start && resp_on) begin
                repeat (2) @(negedge clock);
                bus.move_done = 1'b0;
                repeat (2) @(negedge clock);
                bus.move_done = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.move_valid = 1'b0;
        bus.move_in    = 4'd0;
        bus.go         = 1'b0;
        bus.abort      = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic put(input logic [3:0] c);
        bus.move_in    = c;
        bus.move_valid = 1'b1;
        @(negedge clock);
        bus.move_valid = 1'b0;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        @(negedge clock);
        bus.go = 1'b0;
    endtask

    task automatic wait_seq(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (bus.seq_done) seen = 1'b1;
        end
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (bus.move_start) seen = 1'b1;
        end
    endtask

    // run the FIFO contents and compare the launched stream against exp_q
    task automatic run_check(input string tag);
        bit seen;
        int n;
        starts.delete();
        start_cyc.delete();
        n = exp_q.size();
        pulse_go();
        wait_seq(3000, seen);
        chk({tag, " seq_done seen"}, int'(seen), 1);
        chk({tag, " start count"}, starts.size(), n);
        for (int i = 0; i < n && i < starts.size(); i++)
            chk({tag, " move code"}, int'(starts[i]), int'(exp_q[i]));
        for (int i = 1; i < start_cyc.size(); i++)
            chk({tag, " start spacing ok"}, int'(start_cyc[i] - start_cyc[i-1] >= SETTLE), 1);
        chk({tag, " move_count"}, int'(bus.move_count), n);
        chk({tag, " next_move null"}, int'(bus.next_move), 15);
        chk({tag, " fill at end"}, int'(bus.fill), 0);
        chk({tag, " busy at end"}, int'(bus.busy), 0);
        @(negedge clock);
        chk({tag, " seq_done one cycle"}, int'(bus.seq_done), 0);
    endtask

    initial begin
        bit seen;
        int cnt_sd;
        int cnt_ms;

        vecs[0]  = '{1'b1, 1'b1, 4'd0,  0, 1, 1};
        vecs[1]  = '{1'b0, 1'b1, 4'd14, 0, 1, 1};
        vecs[2]  = '{1'b0, 1'b1, 4'd15, 0, 1, 1};
        vecs[3]  = '{1'b0, 1'b1, 4'd6,  1, 1, 1};
        vecs[4]  = '{1'b1, 1'b0, 4'd7,  0, 0, 1};
        vecs[5]  = '{1'b0, 1'b1, 4'd2,  1, 0, 1};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  2, 0, 1};
        vecs[7]  = '{1'b0, 1'b1, 4'd4,  3, 0, 1};
        vecs[8]  = '{1'b0, 1'b1, 4'd5,  4, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 4'd0,  4, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 4'd11, 4, 0, 0};

        do_reset();
        chk("reset next_move", int'(bus.next_move), 15);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset move_start", int'(bus.move_start), 0);
        chk("reset seq_done", int'(bus.seq_done), 0);
        chk("reset move_count", int'(bus.move_count), 0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].valid) put(vecs[i].code);
            chk($sformatf("vec%0d fill", i), int'(bus.fill), vecs[i].exp_fill);
            chk($sformatf("vec%0d err", i), int'(bus.err), vecs[i].exp_err);
            chk($sformatf("vec%0d ready", i), int'(bus.move_ready), vecs[i].exp_ready);
        end

        // FIFO holds 2,3,4,5 from the table
        exp_q = '{4'd2, 4'd3, 4'd4, 4'd5};
        run_check("drain1");

        // offset the pointers, then overfill across the wrap point
        put(4'd7);
        exp_q = '{4'd7};
        run_check("single");
        for (int k = 0; k < DEPTH + 1; k++) begin
            chk($sformatf("overfill ready%0d", k), int'(bus.move_ready), (k < DEPTH) ? 1 : 0);
            put(4'(8 + k));
        end
        chk("overfill fill", int'(bus.fill), DEPTH);
        exp_q = '{4'd8, 4'd9, 4'd10, 4'd11};
        run_check("wrap");

        // illegal codes then one legal move
        do_reset();
        put(4'd0); put(4'd14); put(4'd15); put(4'd6);
        chk("illegal fill", int'(bus.fill), 1);
        chk("illegal err", int'(bus.err), 1);
        exp_q = '{4'd6};
        run_check("illegal");

        // stepper never goes busy: start timeout
        do_reset();
        resp_on = 1'b0;
        put(4'd3);
        pulse_go();
        wait_start(50, seen);
        chk("timeout start seen", int'(seen), 1);
        repeat (TOUT - 1) @(negedge clock);
        chk("timeout err early", int'(bus.err), 0);
        @(negedge clock);
        chk("timeout err set", int'(bus.err), 2);
        wait_seq(200, seen);
        chk("timeout seq_done", int'(seen), 1);
        chk("timeout move_count", int'(bus.move_count), 0);
        resp_on = 1'b1;
        repeat (4) @(negedge clock);

        // abort during first WAIT_HIGH
        do_reset();
        put(4'd2); put(4'd4); put(4'd8); put(4'd10);
        starts.delete();
        pulse_go();
        wait_start(50, seen);
        chk("abort start seen", int'(seen), 1);
        repeat (3) @(negedge clock);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        wait_seq(500, seen);
        chk("abort seq_done", int'(seen), 1);
        chk("abort starts", starts.size(), 1);
        chk("abort fill", int'(bus.fill), 0);
        chk("abort move_count", int'(bus.move_count), 1);

        // abort in IDLE flushes at once
        put(4'd5); put(4'd6);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        chk("idle abort fill", int'(bus.fill), 0);

        // reset during WAIT_HIGH
        do_reset();
        put(4'd2); put(4'd3);
        pulse_go();
        wait_start(50, seen);
        chk("rst start seen", int'(seen), 1);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst next_move", int'(bus.next_move), 15);
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst move_start", int'(bus.move_start), 0);
        chk("midrst seq_done", int'(bus.seq_done), 0);
        chk("midrst move_count", int'(bus.move_count), 0);
        chk("midrst fill", int'(bus.fill), 0);
        chk("midrst err", int'(bus.err), 0);
        reset_n = 1'b1;
        cnt_sd = 0;
        cnt_ms = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.seq_done) cnt_sd++;
            if (bus.move_start) cnt_ms++;
        end
        chk("midrst no seq_done", cnt_sd, 0);
        chk("midrst no move_start", cnt_ms, 0);

        // randomized runs against a queue model
        for (int it = 0; it < 10; it++) begin
            int n;
            logic ill;
            logic [3:0] c;
            do_reset();
            exp_q.delete();
            ill = 1'b0;
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                c = 4'($urandom_range(0, 15));
                if (exp_q.size() < DEPTH) begin
                    if (c >= 2 && c <= 13) exp_q.push_back(c);
                    else ill = 1'b1;
                end
                put(c);
            end
            chk($sformatf("rnd%0d fill", it), int'(bus.fill), exp_q.size());
            chk($sformatf("rnd%0d err", it), int'(bus.err), int'(ill));
            if (exp_q.size() > 0) begin
                run_check($sformatf("rnd%0d", it));
            end else begin
                pulse_go();
                chk($sformatf("rnd%0d empty go busy", it), int'(bus.busy), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
